// File: rtl/ripple_tick_gen_pkg.sv
// ripple_tick_gen_pkg: shared types, encodings and period helpers for the LED ripple control front end
package ripple_tick_gen_pkg;
    typedef logic [1:0] speed_t;
    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DOWN = 1'b1;
    localparam int SPEED_COUNT = 4;
    localparam int EV_DIR = 0;
    localparam int EV_SPEED = 1;
    localparam int EV_PAUSE = 2;
    function automatic speed_t next_speed(input speed_t s);
        return speed_t'((int'(s) + 1) % SPEED_COUNT);
    endfunction
    function automatic int period_of(input int base, input speed_t s);
        return base >> s;
    endfunction
endpackage

// File: rtl/ripple_tick_gen_btn_debounce.sv
// btn_debounce: two-flop synchroniser, stable-count debouncer and rising-edge detect for one raw button
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    logic sync0, sync1, level, level_q;
    logic [CW-1:0] cnt;
    assign rise = level & ~level_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
            level <= 1'b0;
            level_q <= 1'b0;
            cnt <= '0;
        end else begin
            sync0 <= btn;
            sync1 <= sync0;
            level_q <= level;
            if (sync1 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= ~level;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/ripple_tick_gen.sv
// ripple_tick_gen: button-driven direction/speed/pause control and shift-pulse prescaler for the LED ripple
module ripple_tick_gen
    import ripple_tick_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BASE_PERIOD = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_dir,
    input  logic       btn_speed,
    input  logic       btn_pause,
    output logic       shift_pulse,
    output logic       shift_dir,
    output logic [1:0] speed_sel,
    output logic       paused
);
    localparam int PW = $clog2(BASE_PERIOD);
    logic [2:0] btn, rise, ev;
    logic [PW-1:0] presc, presc_n, pm1, pm1_n;
    speed_t speed_n;
    logic paused_n, pulse_n;
    assign btn = {btn_pause, btn_speed, btn_dir};
    for (genvar i = 0; i < 3; i++) begin : g_btn
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk(clk),
            .reset(reset),
            .btn(btn[i]),
            .rise(rise[i])
        );
    end
    // shift_pulse is computed from next-state so it is a true flop yet still lines up with prescaler == P-1
    always_comb begin
        speed_n = ev[EV_SPEED] ? next_speed(speed_sel) : speed_sel;
        paused_n = paused ^ ev[EV_PAUSE];
        pm1 = PW'(period_of(BASE_PERIOD, speed_sel) - 1);
        pm1_n = PW'(period_of(BASE_PERIOD, speed_n) - 1);
        presc_n = ev[EV_SPEED] ? '0 : paused ? presc : (presc == pm1) ? '0 : presc + PW'(1);
        pulse_n = (presc_n == pm1_n) && !paused_n && !rise[EV_SPEED];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            ev <= '0;
            presc <= '0;
            shift_pulse <= 1'b0;
            shift_dir <= DIR_UP;
            speed_sel <= '0;
            paused <= 1'b0;
        end else begin
            ev <= rise;
            presc <= presc_n;
            shift_pulse <= pulse_n;
            shift_dir <= shift_dir ^ ev[EV_DIR];
            speed_sel <= speed_n;
            paused <= paused_n;
        end
    end
endmodule

// File: tb/tb_ripple_tick_gen.sv
// tb_ripple_tick_gen: scoreboard bench for ripple_tick_gen with short debounce and base period
module tb_ripple_tick_gen;
    localparam int D = 4;
    localparam int B = 16;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_dir = 1'b0, btn_speed = 1'b0, btn_pause = 1'b0;
    logic shift_pulse, shift_dir, paused;
    logic [1:0] speed_sel;

    ripple_tick_gen #(.DEBOUNCE_CYCLES(D), .BASE_PERIOD(B)) dut (
        .clk(clk),
        .reset(reset),
        .btn_dir(btn_dir),
        .btn_speed(btn_speed),
        .btn_pause(btn_pause),
        .shift_pulse(shift_pulse),
        .shift_dir(shift_dir),
        .speed_sel(speed_sel),
        .paused(paused)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        bit pulse;
        int gap;
        logic dir;
        logic [1:0] spd;
        logic pau;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;
    int since = 0;
    logic [3:0] prev = 4'b0;

    task automatic expect_ev(input string name, input bit pulse, input int gap,
                             input logic dir, input logic [1:0] spd, input logic pau);
        exp_t e;
        e.name = name;
        e.pulse = pulse;
        e.gap = gap;
        e.dir = dir;
        e.spd = spd;
        e.pau = pau;
        q.push_back(e);
    endtask

    task automatic score(input bit pulse, input int gap);
        exp_t e;
        tests++;
        if (q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_output: got pulse=%0b gap=%0d dir=%0b spd=%0d pau=%0b, required no output",
                     pulse, gap, shift_dir, speed_sel, paused);
        end else begin
            e = q.pop_front();
            if (e.pulse != pulse || (pulse && e.gap != gap) || e.dir !== shift_dir ||
                e.spd !== speed_sel || e.pau !== paused) begin
                fails++;
                $display("FAIL %s: got pulse=%0b gap=%0d dir=%0b spd=%0d pau=%0b, required pulse=%0b gap=%0d dir=%0b spd=%0d pau=%0b",
                         e.name, pulse, gap, shift_dir, speed_sel, paused,
                         e.pulse, e.gap, e.dir, e.spd, e.pau);
            end
        end
    endtask

    // Monitor: gap counts cycles since the last pulse or the last speed/pause change
    always @(negedge clk) begin
        if (reset) begin
            since = 0;
            prev = 4'b0;
        end else begin
            since++;
            if ({shift_dir, speed_sel, paused} !== prev) begin
                if ({speed_sel, paused} !== prev[2:0]) since = 1;
                score(1'b0, 0);
                prev = {shift_dir, speed_sel, paused};
            end
            if (shift_pulse === 1'b1) begin
                score(1'b1, since);
                since = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        btn_dir = 1'b0;
        btn_speed = 1'b0;
        btn_pause = 1'b0;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic drain(input string name, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (q.size() == 0) break;
            tick();
        end
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL %s_timeout: got %0d outputs still pending, required 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic press_speed(output int lat);
        logic [1:0] old;
        old = speed_sel;
        btn_speed = 1'b1;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (lat == 0 && speed_sel !== old) lat = i;
        end
        btn_speed = 1'b0;
    endtask

    task automatic check_zero(input string name);
        check({name, "_pulse"}, 32'(shift_pulse), 0);
        check({name, "_dir"}, 32'(shift_dir), 0);
        check({name, "_speed"}, 32'(speed_sel), 0);
        check({name, "_paused"}, 32'(paused), 0);
    endtask

    initial begin
        int lat;
        bit found;
        do_reset(3);
        check_zero("reset");
        repeat (3) expect_ev("idle_pulse", 1'b1, 16, 1'b0, 2'd0, 1'b0);
        drain("idle", 60);

        do_reset(3);
        for (int n = 1; n <= 4; n++) begin
            int spd, per, cnt;
            spd = n % 4;
            per = B >> spd;
            cnt = (n < 4) ? (32 / per - 1) : 2;
            expect_ev("speed_ctrl", 1'b0, 0, 1'b0, 2'(spd), 1'b0);
            repeat (cnt) expect_ev("speed_pulse", 1'b1, per, 1'b0, 2'(spd), 1'b0);
            press_speed(lat);
            check("speed_latency", 32'(lat), 32'(D + 4));
            if (n < 4) repeat (22) tick();
            else drain("speed", 60);
        end

        do_reset(3);
        expect_ev("bounce_pulse0", 1'b1, 16, 1'b0, 2'd0, 1'b0);
        expect_ev("bounce_dir", 1'b0, 0, 1'b1, 2'd0, 1'b0);
        expect_ev("bounce_pulse1", 1'b1, 16, 1'b1, 2'd0, 1'b0);
        for (int s = 0; s < 5; s++) begin
            btn_dir = (s % 2 == 0);
            repeat (2) tick();
        end
        repeat (8) tick();
        btn_dir = 1'b0;
        drain("bounce", 60);

        do_reset(3);
        expect_ev("prepause_pulse0", 1'b1, 16, 1'b0, 2'd0, 1'b0);
        expect_ev("prepause_pulse1", 1'b1, 16, 1'b0, 2'd0, 1'b0);
        expect_ev("pause_ctrl", 1'b0, 0, 1'b0, 2'd0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (shift_pulse === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL first_pulse_wait: got no pulse in 40 cycles, required one");
        end
        repeat (15) tick();
        btn_pause = 1'b1;
        repeat (8) tick();
        btn_pause = 1'b0;
        repeat (100) tick();
        check("paused_pending", 32'(q.size()), 0);
        expect_ev("unpause_ctrl", 1'b0, 0, 1'b0, 2'd0, 1'b0);
        expect_ev("resume_pulse", 1'b1, 10, 1'b0, 2'd0, 1'b0);
        expect_ev("resume_pulse_full", 1'b1, 16, 1'b0, 2'd0, 1'b0);
        btn_pause = 1'b1;
        repeat (8) tick();
        btn_pause = 1'b0;
        drain("pause", 60);

        do_reset(3);
        expect_ev("dual_ctrl", 1'b0, 0, 1'b1, 2'd1, 1'b0);
        expect_ev("dual_pulse", 1'b1, 8, 1'b1, 2'd1, 1'b0);
        btn_dir = 1'b1;
        btn_speed = 1'b1;
        repeat (8) tick();
        btn_dir = 1'b0;
        btn_speed = 1'b0;
        drain("dual", 40);

        do_reset(3);
        expect_ev("rst_speed1", 1'b0, 0, 1'b0, 2'd1, 1'b0);
        repeat (3) expect_ev("rst_pulse8", 1'b1, 8, 1'b0, 2'd1, 1'b0);
        expect_ev("rst_speed2", 1'b0, 0, 1'b0, 2'd2, 1'b0);
        expect_ev("post_reset_pulse", 1'b1, 16, 1'b0, 2'd0, 1'b0);
        press_speed(lat);
        repeat (22) tick();
        press_speed(lat);
        check("speed2_before_reset", 32'(speed_sel), 2);
        reset = 1'b1;
        tick();
        check_zero("midreset");
        reset = 1'b0;
        drain("post_reset", 60);

        check("end_pending", 32'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, required finish");
        $fatal(1);
    end
endmodule
